// File: rtl/slave_data_path_param_if.sv
// AHB-lite slave-side bus bundle for the register-file slave data path.
// Also carries the quasi-static base address and the slave response signals.
interface slave_data_path_param_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              hsel;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic              HREADY;
    logic [ADDR_W-1:0] sadd;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] hrdata;
    logic              sl_rdy;
    logic              slrsp;

    modport master (
        output hsel, HADDR, HTRANS, HWRITE, HREADY, sadd, HWDATA,
        input  hrdata, sl_rdy, slrsp
    );

    modport slave (
        input  hsel, HADDR, HTRANS, HWRITE, HREADY, sadd, HWDATA,
        output hrdata, sl_rdy, slrsp
    );
endinterface

// File: rtl/slave_data_path_param.sv
// DEPTH-word AHB-lite register-file slave: runtime base-address decode,
// programmable wait states, two-cycle ERROR response and write-to-read forwarding.
module slave_data_path_param #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WAIT_STATES = 0
) (
    input logic                    clk,
    input logic                    rst,
    slave_data_path_param_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned WIN_W = ADDR_W + 1;
    localparam logic [WIN_W-1:0] WIN = WIN_W'(4 * DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              pend_vld, pend_vld_nxt;
    logic              pend_wr, pend_wr_nxt;
    logic [IDX_W-1:0]  pend_idx, pend_idx_nxt;
    logic              rdy, rdy_nxt;
    logic              rsp, rsp_nxt;
    logic [DATA_W-1:0] rd_q, rd_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] off_c;
    logic              hit_c;
    logic [IDX_W-1:0]  idx_c;
    logic              accept_c;
    logic              commit_c;
    logic              unused_c;

    assign unused_c   = bus.HTRANS[0];
    assign bus.hrdata = rd_q;
    assign bus.sl_rdy = rdy;
    assign bus.slrsp  = rsp;

    // Address decode against the base address sampled at this edge
    always_comb begin
        off_c    = bus.HADDR - bus.sadd;
        hit_c    = ({1'b0, off_c} < WIN) && (bus.HADDR[1:0] == 2'b00);
        idx_c    = off_c[IDX_W+1:2];
        accept_c = bus.hsel && bus.HTRANS[1] && bus.HREADY && rdy;
        // A write commits at the edge that ends its final data cycle
        commit_c = (state == S_IDLE) && pend_vld && pend_wr;
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pend_vld_nxt = pend_vld;
        pend_wr_nxt  = pend_wr;
        pend_idx_nxt = pend_idx;
        rdy_nxt      = rdy;
        rsp_nxt      = rsp;
        rd_nxt       = rd_q;
        case (state)
            S_IDLE, S_ERR2: begin
                state_nxt    = S_IDLE;
                pend_vld_nxt = 1'b0;
                rdy_nxt      = 1'b1;
                rsp_nxt      = 1'b0;
                if (accept_c) begin
                    if (hit_c) begin
                        pend_vld_nxt = 1'b1;
                        pend_wr_nxt  = bus.HWRITE;
                        pend_idx_nxt = idx_c;
                        if (WAIT_STATES > 0) begin
                            state_nxt = S_WAIT;
                            cnt_nxt   = CNT_W'(WAIT_STATES);
                            rdy_nxt   = 1'b0;
                        end else if (!bus.HWRITE) begin
                            // Zero-wait read: forward a same-index write committing now
                            rd_nxt = (commit_c && (pend_idx == idx_c)) ? bus.HWDATA : mem[idx_c];
                        end
                    end else begin
                        state_nxt = S_ERR1;
                        rdy_nxt   = 1'b0;
                        rsp_nxt   = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = S_IDLE;
                    rdy_nxt   = 1'b1;
                    if (!pend_wr) begin
                        rd_nxt = mem[pend_idx];
                    end
                end
            end
            S_ERR1: begin
                state_nxt = S_ERR2;
                rdy_nxt   = 1'b1;
                rsp_nxt   = 1'b1;
            end
            default: begin
                state_nxt = S_IDLE;
                rdy_nxt   = 1'b1;
                rsp_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            pend_vld <= 1'b0;
            pend_wr  <= 1'b0;
            pend_idx <= '0;
            rdy      <= 1'b1;
            rsp      <= 1'b0;
            rd_q     <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            pend_vld <= pend_vld_nxt;
            pend_wr  <= pend_wr_nxt;
            pend_idx <= pend_idx_nxt;
            rdy      <= rdy_nxt;
            rsp      <= rsp_nxt;
            rd_q     <= rd_nxt;
        end
    end

    // Register file storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (commit_c) begin
            mem[pend_idx] <= bus.HWDATA;
        end
    end
endmodule

// File: tb/tb_slave_data_path_param.sv
// Directed bench: zero-wait instance (a) and two-wait-state instance (b) sharing clk/rst.
module tb_slave_data_path_param;
    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;

    slave_data_path_param_if #(.ADDR_W(16), .DATA_W(32)) ifa ();
    slave_data_path_param_if #(.ADDR_W(16), .DATA_W(32)) ifb ();

    // Single-slave interconnect: bus HREADY follows the slave's ready
    assign ifa.HREADY = ifa.sl_rdy;
    assign ifb.HREADY = ifb.sl_rdy;

    slave_data_path_param #(.ADDR_W(16), .DATA_W(32), .DEPTH(16), .WAIT_STATES(0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    slave_data_path_param #(.ADDR_W(16), .DATA_W(32), .DEPTH(16), .WAIT_STATES(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_addr(input logic s, input logic [1:0] t, input logic w, input logic [15:0] ad);
        ifa.hsel = s; ifa.HTRANS = t; ifa.HWRITE = w; ifa.HADDR = ad;
    endtask

    task automatic b_addr(input logic s, input logic [1:0] t, input logic w, input logic [15:0] ad);
        ifb.hsel = s; ifb.HTRANS = t; ifb.HWRITE = w; ifb.HADDR = ad;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst = 1'b0;
        a_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        b_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        ifa.sadd = 16'h1000; ifa.HWDATA = '0;
        ifb.sadd = 16'h1000; ifb.HWDATA = '0;
        step();
        step();
        rst = 1'b1;

        chk("a_reset_rdy",  32'(ifa.sl_rdy), 32'd1);
        chk("a_reset_rsp",  32'(ifa.slrsp),  32'd0);
        chk("a_reset_data", ifa.hrdata,      32'h0);
        chk("b_reset_rdy",  32'(ifb.sl_rdy), 32'd1);

        // Read base word after reset
        a_addr(1'b1, 2'b10, 1'b0, 16'h1000);
        step();
        chk("a_rd0_data", ifa.hrdata,      32'h0);
        chk("a_rd0_rdy",  32'(ifa.sl_rdy), 32'd1);
        chk("a_rd0_rsp",  32'(ifa.slrsp),  32'd0);

        // Write then immediately read the same word: forwarded data, no stall
        a_addr(1'b1, 2'b10, 1'b1, 16'h1008);
        step();
        ifa.HWDATA = 32'hDEADBEEF;
        a_addr(1'b1, 2'b10, 1'b0, 16'h1008);
        step();
        chk("a_fwd_data", ifa.hrdata,      32'hDEADBEEF);
        chk("a_fwd_rdy",  32'(ifa.sl_rdy), 32'd1);
        a_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        a_addr(1'b1, 2'b10, 1'b0, 16'h1008);
        step();
        chk("a_mem_data", ifa.hrdata, 32'hDEADBEEF);

        // Write word 0 then read word 1 back-to-back: different index, no forwarding
        a_addr(1'b1, 2'b10, 1'b1, 16'h1000);
        step();
        ifa.HWDATA = 32'hA5A5A5A5;
        a_addr(1'b1, 2'b10, 1'b0, 16'h1004);
        step();
        chk("a_nofwd_data", ifa.hrdata, 32'h0);
        a_addr(1'b1, 2'b10, 1'b0, 16'h1008);
        step();
        chk("a_rd8_data", ifa.hrdata, 32'hDEADBEEF);

        // Out-of-window write aliasing word 0
        a_addr(1'b1, 2'b10, 1'b1, 16'h1040);
        step();
        chk("a_oow_err1_rdy", 32'(ifa.sl_rdy), 32'd0);
        chk("a_oow_err1_rsp", 32'(ifa.slrsp),  32'd1);
        ifa.HWDATA = 32'hFFFFFFFF;
        a_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        chk("a_oow_err2_rdy", 32'(ifa.sl_rdy), 32'd1);
        chk("a_oow_err2_rsp", 32'(ifa.slrsp),  32'd1);
        chk("a_oow_hold",     ifa.hrdata,      32'hDEADBEEF);
        step();
        chk("a_oow_done_rsp", 32'(ifa.slrsp),  32'd0);
        chk("a_oow_done_rdy", 32'(ifa.sl_rdy), 32'd1);

        // Misaligned write, with a read issued during ERR2
        a_addr(1'b1, 2'b10, 1'b1, 16'h1002);
        step();
        chk("a_mis_err1_rdy", 32'(ifa.sl_rdy), 32'd0);
        chk("a_mis_err1_rsp", 32'(ifa.slrsp),  32'd1);
        ifa.HWDATA = 32'hFFFFFFFF;
        a_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        chk("a_mis_err2_rdy", 32'(ifa.sl_rdy), 32'd1);
        chk("a_mis_err2_rsp", 32'(ifa.slrsp),  32'd1);
        a_addr(1'b1, 2'b10, 1'b0, 16'h1000);
        step();
        chk("a_err_nowrite", ifa.hrdata,     32'hA5A5A5A5);
        chk("a_err2_acc_rsp", 32'(ifa.slrsp), 32'd0);

        // BUSY to an out-of-window address: zero-wait OKAY, no side effects
        a_addr(1'b1, 2'b01, 1'b0, 16'h1040);
        step();
        chk("a_busy_rdy",  32'(ifa.sl_rdy), 32'd1);
        chk("a_busy_rsp",  32'(ifa.slrsp),  32'd0);
        step();
        chk("a_busy_rsp2", 32'(ifa.slrsp),  32'd0);
        chk("a_busy_data", ifa.hrdata,      32'hA5A5A5A5);
        a_addr(1'b0, 2'b00, 1'b0, 16'h0000);

        // Two wait states: write then read
        b_addr(1'b1, 2'b10, 1'b1, 16'h1004);
        step();
        chk("b_wr_w1_rdy", 32'(ifb.sl_rdy), 32'd0);
        ifb.HWDATA = 32'h12345678;
        b_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        chk("b_wr_w2_rdy", 32'(ifb.sl_rdy), 32'd0);
        step();
        chk("b_wr_fin_rdy", 32'(ifb.sl_rdy), 32'd1);
        chk("b_wr_fin_rsp", 32'(ifb.slrsp),  32'd0);
        b_addr(1'b1, 2'b10, 1'b0, 16'h1004);
        step();
        chk("b_rd_w1_rdy", 32'(ifb.sl_rdy), 32'd0);
        b_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        step();
        chk("b_rd_data", ifb.hrdata,      32'h12345678);
        chk("b_rd_rdy",  32'(ifb.sl_rdy), 32'd1);

        // Error latency is two cycles regardless of wait states
        b_addr(1'b1, 2'b10, 1'b0, 16'h1040);
        step();
        chk("b_err1_rsp", 32'(ifb.slrsp), 32'd1);
        b_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        chk("b_err2_rdy", 32'(ifb.sl_rdy), 32'd1);
        step();
        chk("b_err_done_rsp", 32'(ifb.slrsp), 32'd0);

        // Reset during the wait of a write aborts it
        b_addr(1'b1, 2'b10, 1'b1, 16'h100C);
        step();
        chk("b_rstw_rdy", 32'(ifb.sl_rdy), 32'd0);
        ifb.HWDATA = 32'hCAFEF00D;
        b_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        #3;
        rst = 1'b0;
        #1;
        chk("b_rst_rdy",  32'(ifb.sl_rdy), 32'd1);
        chk("b_rst_rsp",  32'(ifb.slrsp),  32'd0);
        chk("b_rst_data", ifb.hrdata,      32'h0);
        chk("a_rst_data", ifa.hrdata,      32'h0);
        step();
        rst = 1'b1;

        b_addr(1'b1, 2'b10, 1'b1, 16'h1008);
        step();
        ifb.HWDATA = 32'h55AA55AA;
        b_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        step();
        chk("b_wr2_fin_rdy", 32'(ifb.sl_rdy), 32'd1);
        b_addr(1'b1, 2'b10, 1'b0, 16'h1008);
        step();
        b_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        step();
        chk("b_rd8_data", ifb.hrdata, 32'h55AA55AA);
        b_addr(1'b1, 2'b10, 1'b0, 16'h100C);
        step();
        b_addr(1'b0, 2'b00, 1'b0, 16'h0000);
        step();
        step();
        chk("b_rdc_aborted", ifb.hrdata, 32'h0);
        chk("b_rdc_rdy", 32'(ifb.sl_rdy), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
